// File: rtl/mainboard_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the mainboard 8-bit slave port.
// Optional stb-to-ack watchdog: define MAINBOARD_WB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, slave port outputs all zero
// OWN0  | m0 (overlay/debug CPU) owns the slave port
// OWN1  | m1 (ROM image loader) owns the slave port
module mainboard_wb_arbiter #(
  parameter int ADDR_BITS      = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [0:ADDR_BITS-1] m0_adr_i,
  input  logic [7:0]           m0_dat_i,
  output logic [7:0]           m0_dat_o,
  input  logic                 m0_we_i,
  input  logic                 m0_sel_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_cyc_i,
  output logic                 m0_ack_o,

  input  logic [0:ADDR_BITS-1] m1_adr_i,
  input  logic [7:0]           m1_dat_i,
  output logic [7:0]           m1_dat_o,
  input  logic                 m1_we_i,
  input  logic                 m1_sel_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_cyc_i,
  output logic                 m1_ack_o,

  output logic [0:ADDR_BITS-1] s_adr_o,
  output logic [7:0]           s_dat_o,
  output logic                 s_we_o,
  output logic                 s_sel_o,
  output logic                 s_stb_o,
  output logic                 s_cyc_o,
  input  logic [7:0]           s_dat_i,
  input  logic                 s_ack_i,

  output logic [1:0]           grant,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_owner, last_owner_nxt;
  logic   sel0, sel1;
  logic   owner_stb;
  logic   slave_ack;
  logic   tmo_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Ownership only changes when the owner drops cyc; handoff skips IDLE if the other master waits.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_owner ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_nxt = OWN0;
        else if (m1_cyc_i)        state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          last_owner_nxt = 1'b0;
          state_nxt      = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          last_owner_nxt = 1'b1;
          state_nxt      = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel0      = (state == OWN0);
  assign sel1      = (state == OWN1);
  assign owner_stb = (sel0 & m0_stb_i) | (sel1 & m1_stb_i);
  assign slave_ack = s_ack_i & owner_stb;

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = 8'h00;
    s_we_o   = 1'b0;
    s_sel_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = 8'h00;
    m1_dat_o = 8'h00;
    if (sel0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_cyc_o = m0_cyc_i;
    end else if (sel1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_cyc_o = m1_cyc_i;
    end
    // A slave ack landing on a reset edge belongs to a transfer that is being torn down.
    if (!reset) begin
      if (sel0) begin
        m0_ack_o = slave_ack | tmo_fire;
        m0_dat_o = tmo_fire ? 8'hFF : s_dat_i;
      end
      if (sel1) begin
        m1_ack_o = slave_ack | tmo_fire;
        m1_dat_o = tmo_fire ? 8'hFF : s_dat_i;
      end
    end
    s_stb_o = owner_stb & ~tmo_fire;
  end

  assign grant = {sel0, sel1};

`ifdef MAINBOARD_WB_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_err_q;

  assign tmo_fire = owner_stb && !s_ack_i && !reset &&
                    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (s_ack_i || !owner_stb || tmo_fire || (state_nxt != state)) tmo_cnt <= '0;
      else                                                           tmo_cnt <= tmo_cnt + 16'd1;
      if (tmo_fire) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  // Legal TIMEOUT_CYCLES is never 0, so this is constant low without the watchdog.
  assign tmo_fire    = (TIMEOUT_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mainboard_wb_arbiter.sv
// Self-checking bench for mainboard_wb_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural ownership model.
module tb_mainboard_wb_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:23] m0_adr, m1_adr, s_adr;
  logic [7:0]  m0_wdat, m0_rdat, m1_wdat, m1_rdat, s_wdat, s_rdat;
  logic        m0_we, m0_sel, m0_stb, m0_cyc, m0_ack;
  logic        m1_we, m1_sel, m1_stb, m1_cyc, m1_ack;
  logic        s_we, s_sel, s_stb, s_cyc, s_ack;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mainboard_wb_arbiter #(.ADDR_BITS(24), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    reset = 1'b0;
    m0_adr = '0; m0_wdat = 8'h00; m0_we = 1'b0; m0_sel = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
    m1_adr = '0; m1_wdat = 8'h00; m1_we = 1'b0; m1_sel = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
    s_rdat = 8'h00; s_ack = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    all_idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  // Columns: inputs {rst,c0,s0,c1,s1,ack}, expected {grant[1:0],s_cyc,s_stb,ack0,ack1}
  typedef struct packed {
    logic       rst, c0, s0, c1, s1, ack;
    logic [1:0] grant;
    logic       scyc, sstb, a0, a1;
  } vec_t;

  function automatic vec_t mkv(input logic [5:0] ins, input logic [5:0] outs);
    return vec_t'({ins, outs});
  endfunction

  vec_t tbl[24];

  // Behavioural model: owner -1 = nobody, waited = consecutive unacked stb cycles of the owner.
  int m_owner, m_last, m_waited;
  bit m_err;

  function automatic bit model_fire();
    bit stb_own;
`ifdef MAINBOARD_WB_ARB_TIMEOUT_EN
    stb_own = (m_owner == 0) ? m0_stb : (m_owner == 1) ? m1_stb : 1'b0;
    return stb_own && !s_ack && !reset && (m_waited + 1 >= TMO);
`else
    stb_own = 1'b0;
    return stb_own;
`endif
  endfunction

  task automatic model_edge();
    bit cyc[2];
    bit stb[2];
    bit fire;
    int prev;
    cyc[0] = m0_cyc; cyc[1] = m1_cyc;
    stb[0] = m0_stb; stb[1] = m1_stb;
    fire = model_fire();
    prev = m_owner;
    if (reset) begin
      m_owner = -1; m_last = 1; m_waited = 0; m_err = 1'b0;
    end else begin
      if (fire) m_err = 1'b1;
      if (m_owner < 0) begin
        if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
        else if (cyc[0])      m_owner = 0;
        else if (cyc[1])      m_owner = 1;
      end else if (!cyc[m_owner]) begin
        m_last  = m_owner;
        m_owner = cyc[1 - m_owner] ? 1 - m_owner : -1;
      end
      if (prev >= 0 && m_owner == prev && stb[prev] && !s_ack && !fire) m_waited++;
      else m_waited = 0;
    end
  endtask

  task automatic model_check();
    bit          fire;
    bit          stb_own;
    logic [0:23] e_adr;
    logic [7:0]  e_wdat;
    logic        e_we, e_sel, e_cyc;
    fire    = model_fire();
    stb_own = (m_owner == 0) ? m0_stb : (m_owner == 1) ? m1_stb : 1'b0;
    e_adr   = (m_owner == 0) ? m0_adr  : (m_owner == 1) ? m1_adr  : 24'h0;
    e_wdat  = (m_owner == 0) ? m0_wdat : (m_owner == 1) ? m1_wdat : 8'h00;
    e_we    = (m_owner == 0) ? m0_we   : (m_owner == 1) ? m1_we   : 1'b0;
    e_sel   = (m_owner == 0) ? m0_sel  : (m_owner == 1) ? m1_sel  : 1'b0;
    e_cyc   = (m_owner == 0) ? m0_cyc  : (m_owner == 1) ? m1_cyc  : 1'b0;
    chk("rnd_grant", 32'(grant), 32'({m_owner == 0, m_owner == 1}));
    chk("rnd_s_adr", 32'(s_adr), 32'(e_adr));
    chk("rnd_s_dat", 32'(s_wdat), 32'(e_wdat));
    chk("rnd_s_we",  32'(s_we),  32'(e_we));
    chk("rnd_s_sel", 32'(s_sel), 32'(e_sel));
    chk("rnd_s_cyc", 32'(s_cyc), 32'(e_cyc));
    chk("rnd_s_stb", 32'(s_stb), 32'(stb_own && !fire));
    chk("rnd_ack0", 32'(m0_ack), 32'(m_owner == 0 && !reset && ((s_ack && stb_own) || fire)));
    chk("rnd_ack1", 32'(m1_ack), 32'(m_owner == 1 && !reset && ((s_ack && stb_own) || fire)));
    chk("rnd_dat0", 32'(m0_rdat),
        32'((m_owner == 0 && !reset) ? (fire ? 8'hFF : s_rdat) : 8'h00));
    chk("rnd_dat1", 32'(m1_rdat),
        32'((m_owner == 1 && !reset) ? (fire ? 8'hFF : s_rdat) : 8'h00));
    chk("rnd_terr", 32'(timeout_err), 32'(m_err));
  endtask

  initial begin
    tbl[0]  = mkv(6'b011000, 6'b00_0000);
    tbl[1]  = mkv(6'b011000, 6'b10_1100);
    tbl[2]  = mkv(6'b011001, 6'b10_1110);
    tbl[3]  = mkv(6'b000000, 6'b10_0000);
    tbl[4]  = mkv(6'b100000, 6'b00_0000);
    tbl[5]  = mkv(6'b011110, 6'b00_0000);
    tbl[6]  = mkv(6'b011111, 6'b10_1110);
    tbl[7]  = mkv(6'b000110, 6'b10_0000);
    tbl[8]  = mkv(6'b011111, 6'b01_1101);
    tbl[9]  = mkv(6'b011000, 6'b01_0000);
    tbl[10] = mkv(6'b011111, 6'b10_1110);
    tbl[11] = mkv(6'b000110, 6'b10_0000);
    tbl[12] = mkv(6'b011111, 6'b01_1101);
    tbl[13] = mkv(6'b011000, 6'b01_0000);
    tbl[14] = mkv(6'b011111, 6'b10_1110);
    tbl[15] = mkv(6'b000110, 6'b10_0000);
    tbl[16] = mkv(6'b000111, 6'b01_1101);
    tbl[17] = mkv(6'b000000, 6'b01_0000);
    tbl[18] = mkv(6'b000001, 6'b00_0000);
    tbl[19] = mkv(6'b000101, 6'b00_0000);
    tbl[20] = mkv(6'b000101, 6'b01_1000);
    tbl[21] = mkv(6'b000111, 6'b01_1101);
    tbl[22] = mkv(6'b000000, 6'b01_0000);
    tbl[23] = mkv(6'b000000, 6'b00_0000);

    all_idle();
    reset = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; s_rdat = 8'hFF;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(2'b00));
    chk("rst_s_cyc", 32'(s_cyc), 32'(0));
    chk("rst_s_stb", 32'(s_stb), 32'(0));
    chk("rst_ack0",  32'(m0_ack), 32'(0));
    chk("rst_dat0",  32'(m0_rdat), 32'(0));
    chk("rst_terr",  32'(timeout_err), 32'(0));
    next_cycle();
    all_idle();

    // Vector table: single read, round-robin handoff, ignored acks.
    foreach (tbl[i]) begin
      next_cycle();
      reset  = tbl[i].rst;
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_adr = 24'h010000; m0_we = 1'b0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; m1_adr = 24'h300000; m1_we = 1'b1;
      m1_wdat = 8'h3C;
      s_ack  = tbl[i].ack; s_rdat = 8'hA5;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_s_cyc", i), 32'(s_cyc), 32'(tbl[i].scyc));
      chk($sformatf("tbl%0d_s_stb", i), 32'(s_stb), 32'(tbl[i].sstb));
      chk($sformatf("tbl%0d_ack0", i), 32'(m0_ack), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_ack1", i), 32'(m1_ack), 32'(tbl[i].a1));
      chk($sformatf("tbl%0d_s_adr", i), 32'(s_adr),
          (tbl[i].grant == 2'b10) ? 32'h010000 : (tbl[i].grant == 2'b01) ? 32'h300000 : 32'h0);
      if (tbl[i].a0) chk($sformatf("tbl%0d_dat0", i), 32'(m0_rdat), 32'hA5);
      if (tbl[i].a1) chk($sformatf("tbl%0d_dat1", i), 32'(m1_rdat), 32'hA5);
      if (tbl[i].grant != 2'b10) chk($sformatf("tbl%0d_dat0_z", i), 32'(m0_rdat), 32'h0);
      if (tbl[i].grant != 2'b01) chk($sformatf("tbl%0d_dat1_z", i), 32'(m1_rdat), 32'h0);
    end

    // m1 write burst holds the bus while m0 waits.
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 24'h300000;
    @(negedge clk);
    chk("burst_idle_grant", 32'(grant), 32'(2'b00));
    for (int i = 0; i < 64; i++) begin
      next_cycle();
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 24'h010000;
      m1_adr = 24'h300000 + 24'(i); m1_wdat = 8'(i); s_ack = 1'b1;
      @(negedge clk);
      chk("burst_grant", 32'(grant), 32'(2'b01));
      chk("burst_ack1",  32'(m1_ack), 32'(1));
      chk("burst_ack0",  32'(m0_ack), 32'(0));
      chk("burst_s_adr", 32'(s_adr), 32'h300000 + 32'(i));
      chk("burst_s_dat", 32'(s_wdat), 32'(i));
    end
    next_cycle();
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    chk("burst_drop_grant", 32'(grant), 32'(2'b01));
    chk("burst_drop_ack0",  32'(m0_ack), 32'(0));
    next_cycle();
    s_ack = 1'b1; s_rdat = 8'h77;
    @(negedge clk);
    chk("burst_m0_grant", 32'(grant), 32'(2'b10));
    chk("burst_m0_ack",   32'(m0_ack), 32'(1));
    chk("burst_m0_dat",   32'(m0_rdat), 32'h77);

    // Reset while m1 owns the bus with an ack arriving.
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 24'h123456;
    next_cycle();
    @(negedge clk);
    chk("rstmid_own_grant", 32'(grant), 32'(2'b01));
    next_cycle();
    reset = 1'b1; s_ack = 1'b1; s_rdat = 8'h5A;
    @(negedge clk);
    chk("rstmid_ack_drop", 32'(m1_ack), 32'(0));
    next_cycle();
    reset = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    chk("rstmid_grant", 32'(grant), 32'(2'b00));
    chk("rstmid_s_cyc", 32'(s_cyc), 32'(0));
    chk("rstmid_ack1",  32'(m1_ack), 32'(0));
    next_cycle();
    s_ack = 1'b1;
    @(negedge clk);
    chk("rstmid_regrant", 32'(grant), 32'(2'b01));
    chk("rstmid_reack",   32'(m1_ack), 32'(1));
    chk("rstmid_redat",   32'(m1_rdat), 32'h5A);

    // Never-acking slave.
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 24'h020000;
`ifdef MAINBOARD_WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("tmo_ack_k%0d", k), 32'(m0_ack), 32'(k == TMO));
      chk($sformatf("tmo_stb_k%0d", k), 32'(s_stb), 32'(k != TMO));
      if (k == TMO) chk("tmo_dat", 32'(m0_rdat), 32'hFF);
      chk($sformatf("tmo_err_k%0d", k), 32'(timeout_err), 32'(0));
    end
    next_cycle();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    chk("tmo_err_set", 32'(timeout_err), 32'(1));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      chk("tmo_err_sticky", 32'(timeout_err), 32'(1));
    end
    next_cycle();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    s_ack = 1'b1; s_rdat = 8'h42;
    @(negedge clk);
    chk("tmo_next_ack", 32'(m0_ack), 32'(1));
    chk("tmo_next_dat", 32'(m0_rdat), 32'h42);
    chk("tmo_next_err", 32'(timeout_err), 32'(1));
`else
    for (int k = 1; k <= 1000; k++) begin
      next_cycle();
      @(negedge clk);
      chk("stall_ack",   32'(m0_ack), 32'(0));
      chk("stall_err",   32'(timeout_err), 32'(0));
      chk("stall_grant", 32'(grant), 32'(2'b10));
    end
`endif

    // Randomized traffic against the ownership model.
    do_reset();
    m_owner = -1; m_last = 1; m_waited = 0; m_err = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      model_edge();
      #1;
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb  = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb  = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_adr  = 24'($urandom); m1_adr = 24'($urandom);
      m0_wdat = 8'($urandom);  m1_wdat = 8'($urandom);
      m0_we   = 1'($urandom);  m1_we = 1'($urandom);
      m0_sel  = 1'($urandom);  m1_sel = 1'($urandom);
      s_ack   = 1'($urandom);
      s_rdat  = 8'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
